// File: rtl/yutorina_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// yutorina_bus_arbiter_if
//   Request/grant bundle between the bus masters and the round-robin bus
//   arbiter. All request and grant lines are active-low.
//
//   m_req_     per-master bus request (driven by the masters)
//   m_grnt_    per-master bus grant, at most one bit low (driven by arbiter)
//   owner      index of the current grant holder, valid when owner_vld
//   owner_vld  a grant is outstanding
//   preempt    one-cycle pulse when a grant is withdrawn by the hold limit
//
//   modport master : the requesting side
//   modport slave  : the arbiter side
// ----------------------------------------------------------------------------
interface yutorina_bus_arbiter_if #(
   parameter int NUM_M = 4,
   parameter int ID_W  = 2
);
   logic [NUM_M-1:0] m_req_;
   logic [NUM_M-1:0] m_grnt_;
   logic [ID_W-1:0]  owner;
   logic             owner_vld;
   logic             preempt;

   modport master (
      output m_req_,
      input  m_grnt_, owner, owner_vld, preempt
   );

   modport slave (
      input  m_req_,
      output m_grnt_, owner, owner_vld, preempt
   );
endinterface

// File: rtl/yutorina_bus_arbiter.sv
// ----------------------------------------------------------------------------
// yutorina_bus_arbiter
//   Round-robin arbiter for the shared system bus. A master pulls its req_
//   low and waits for its grnt_ to go low before driving the bus. When the
//   owner releases, the next requester is granted on the same edge. With
//   MAX_HOLD != 0 an owner that keeps the bus for MAX_HOLD cycles while
//   someone else waits is pre-empted: the grant is dropped for one DRAIN
//   cycle (preempt pulses) and then passed on, the old owner ranking last.
//
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   arbiter side of yutorina_bus_arbiter_if (m_req_ in; m_grnt_,
//         owner, owner_vld, preempt out, all registered)
// ----------------------------------------------------------------------------
module yutorina_bus_arbiter #(
   parameter int NUM_M    = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 16
) (
   input logic                   clk,
   input logic                   rst,
   yutorina_bus_arbiter_if.slave bus
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam bit LIMIT_EN = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = LIMIT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [NUM_M-1:0]  grnt_q, grnt_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic              vld_q, vld_d;
   logic              preempt_q, preempt_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic [NUM_M-1:0]  req_act;
   logic              owner_req;
   logic              others_req;
   logic              win_vld;
   logic [ID_W-1:0]   win_idx;

   // Index k positions after base, wrapping at NUM_M.
   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
      return ID_W'((int'(base) + k) % NUM_M);
   endfunction

   assign req_act    = ~bus.m_req_;
   assign owner_req  = req_act[owner_q];
   assign others_req = |(req_act & ~(NUM_M'(1) << owner_q));

   // Round-robin pick starting at last_q+1. Scanning from the far end down
   // lets the nearest requester overwrite. In every state the search base is
   // last_q: on release last_q equals the owner, whose req_ is high and so
   // drops out by itself; after a pre-empt the old owner lands last.
   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = NUM_M; k >= 1; k--) begin
         if (!bus.m_req_[rr_idx(last_q, k)]) begin
            win_vld = 1'b1;
            win_idx = rr_idx(last_q, k);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grnt_d    = grnt_q;
      owner_d   = owner_q;
      vld_d     = vld_q;
      preempt_d = 1'b0;
      last_d    = last_q;
      hold_d    = hold_q;

      unique case (state_q)
         ST_IDLE, ST_DRAIN: begin
            if (win_vld) begin
               state_d = ST_GRANT;
               grnt_d  = ~(NUM_M'(1) << win_idx);
               owner_d = win_idx;
               vld_d   = 1'b1;
               last_d  = win_idx;
               hold_d  = '0;
            end else begin
               state_d = ST_IDLE;
               grnt_d  = '1;
               vld_d   = 1'b0;
            end
         end

         ST_GRANT: begin
            if (!owner_req) begin
               // Release wins over pre-empt; hand over with no gap cycle.
               if (win_vld) begin
                  grnt_d  = ~(NUM_M'(1) << win_idx);
                  owner_d = win_idx;
                  last_d  = win_idx;
                  hold_d  = '0;
               end else begin
                  state_d = ST_IDLE;
                  grnt_d  = '1;
                  vld_d   = 1'b0;
                  hold_d  = '0;
               end
            end else if (LIMIT_EN && others_req && hold_q == HOLD_LAST) begin
               state_d   = ST_DRAIN;
               grnt_d    = '1;
               vld_d     = 1'b0;
               preempt_d = 1'b1;
               hold_d    = '0;
            end else if (others_req) begin
               if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
            end else begin
               // A lone owner is not starving anyone.
               hold_d = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            grnt_d  = '1;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= ST_IDLE;
         grnt_q    <= '1;
         owner_q   <= '0;
         vld_q     <= 1'b0;
         preempt_q <= 1'b0;
         last_q    <= ID_W'(NUM_M - 1);
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         grnt_q    <= grnt_d;
         owner_q   <= owner_d;
         vld_q     <= vld_d;
         preempt_q <= preempt_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
      end
   end

   assign bus.m_grnt_   = grnt_q;
   assign bus.owner     = owner_q;
   assign bus.owner_vld = vld_q;
   assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_yutorina_bus_arbiter
//   Directed bench for yutorina_bus_arbiter. Two instances share clk/rst:
//   dut16 (MAX_HOLD=16) and dut4 (MAX_HOLD=4). Inputs change 1 ns after the
//   rising edge and outputs are sampled there, away from the active edge.
// ----------------------------------------------------------------------------
module tb_yutorina_bus_arbiter;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   yutorina_bus_arbiter_if #(.NUM_M(4), .ID_W(2)) bus16 ();
   yutorina_bus_arbiter_if #(.NUM_M(4), .ID_W(2)) bus4 ();

   yutorina_bus_arbiter #(.NUM_M(4), .ID_W(2), .MAX_HOLD(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   yutorina_bus_arbiter #(.NUM_M(4), .ID_W(2), .MAX_HOLD(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants after one edge, given the requests present before that edge.
   task automatic inv(input string tag, input logic [3:0] g, input logic [1:0] o,
                      input logic v, input logic [3:0] pr);
      check({tag, "_onehot"}, 32'($countones(~g) <= 1), 32'd1);
      if (v) begin
         check({tag, "_grnt_owner"}, {28'd0, g}, {28'd0, ~(4'b0001 << o)});
         check({tag, "_req_low"}, {31'd0, pr[o]}, 32'd0);
      end else begin
         check({tag, "_no_grnt"}, {28'd0, g}, 32'hF);
      end
   endtask

   initial begin
      logic [3:0] prev16, prev4;
      int exp_o;

      rst = 1'b1;
      bus16.m_req_ = 4'b1111;
      bus4.m_req_  = 4'b1111;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_grnt", {28'd0, bus16.m_grnt_}, 32'hF);
      check("rst_vld", {31'd0, bus16.owner_vld}, 32'd0);
      check("rst_owner", {30'd0, bus16.owner}, 32'd0);
      check("rst_preempt", {31'd0, bus16.preempt}, 32'd0);

      // 1: single request, one-cycle latency
      bus16.m_req_ = 4'b1110;
      tick();
      check("t1_grnt", {28'd0, bus16.m_grnt_}, 32'hE);
      check("t1_owner", {30'd0, bus16.owner}, 32'd0);
      check("t1_vld", {31'd0, bus16.owner_vld}, 32'd1);
      bus16.m_req_ = 4'b1111;
      tick();
      check("t1_rel_grnt", {28'd0, bus16.m_grnt_}, 32'hF);
      check("t1_rel_vld", {31'd0, bus16.owner_vld}, 32'd0);
      check("t1_rel_owner", {30'd0, bus16.owner}, 32'd0);

      // 2: m0 and m2 together after reset, then hand-over with no gap
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus16.m_req_ = 4'b1010;
      tick();
      check("t2_grnt0", {28'd0, bus16.m_grnt_}, 32'hE);
      check("t2_owner0", {30'd0, bus16.owner}, 32'd0);
      bus16.m_req_ = 4'b1011;
      tick();
      check("t2_grnt2", {28'd0, bus16.m_grnt_}, 32'hB);
      check("t2_owner2", {30'd0, bus16.owner}, 32'd2);
      check("t2_vld2", {31'd0, bus16.owner_vld}, 32'd1);
      bus16.m_req_ = 4'b1111;
      tick();
      check("t2_idle", {28'd0, bus16.m_grnt_}, 32'hF);

      // 3a: wrap from last=3 to m0
      bus16.m_req_ = 4'b0111;
      tick();
      check("t3_grnt3", {28'd0, bus16.m_grnt_}, 32'h7);
      bus16.m_req_ = 4'b1110;
      tick();
      check("t3_wrap_grnt", {28'd0, bus16.m_grnt_}, 32'hE);
      check("t3_wrap_owner", {30'd0, bus16.owner}, 32'd0);
      bus16.m_req_ = 4'b1111;
      tick();

      // 3b: fairness, all request, each owner releases after 2 cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus16.m_req_ = 4'b0000;
      tick();
      for (int i = 0; i < 5; i++) begin
         exp_o = i % 4;
         check("t3_rr_owner", {30'd0, bus16.owner}, 32'(exp_o));
         check("t3_rr_grnt", {28'd0, bus16.m_grnt_}, {28'd0, ~(4'b0001 << exp_o)});
         tick();
         check("t3_rr_hold", {30'd0, bus16.owner}, 32'(exp_o));
         bus16.m_req_[exp_o] = 1'b1;
         tick();
         bus16.m_req_[exp_o] = 1'b0;
      end
      bus16.m_req_ = 4'b1111;
      tick();
      check("t3_rr_end_vld", {31'd0, bus16.owner_vld}, 32'd0);

      // 4: MAX_HOLD=4, m1 holds while m3 waits
      bus4.m_req_ = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_hold_grnt", {28'd0, bus4.m_grnt_}, 32'hD);
         check("t4_hold_pre", {31'd0, bus4.preempt}, 32'd0);
      end
      tick();
      check("t4_drain_grnt", {28'd0, bus4.m_grnt_}, 32'hF);
      check("t4_drain_pre", {31'd0, bus4.preempt}, 32'd1);
      check("t4_drain_vld", {31'd0, bus4.owner_vld}, 32'd0);
      tick();
      check("t4_next_grnt", {28'd0, bus4.m_grnt_}, 32'h7);
      check("t4_next_owner", {30'd0, bus4.owner}, 32'd3);
      check("t4_next_pre", {31'd0, bus4.preempt}, 32'd0);
      bus4.m_req_ = 4'b1111;
      tick();
      check("t4_idle", {28'd0, bus4.m_grnt_}, 32'hF);

      // 5: m1 alone for 40 cycles; the hold count must still start from 0
      // when m3 arrives, giving exactly 16 grant cycles before pre-empt.
      bus16.m_req_ = 4'b1101;
      for (int i = 0; i < 40; i++) begin
         tick();
         check("t5_alone_grnt", {28'd0, bus16.m_grnt_}, 32'hD);
         check("t5_alone_pre", {31'd0, bus16.preempt}, 32'd0);
      end
      bus16.m_req_ = 4'b0101;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("t5_wait_grnt", {28'd0, bus16.m_grnt_}, 32'hD);
         check("t5_wait_pre", {31'd0, bus16.preempt}, 32'd0);
      end
      tick();
      check("t5_pre", {31'd0, bus16.preempt}, 32'd1);
      check("t5_pre_grnt", {28'd0, bus16.m_grnt_}, 32'hF);
      tick();
      check("t5_next_grnt", {28'd0, bus16.m_grnt_}, 32'h7);
      bus16.m_req_ = 4'b1111;
      tick();

      // 6: reset while m2 holds the bus
      bus16.m_req_ = 4'b1011;
      tick();
      check("t6_grnt2", {28'd0, bus16.m_grnt_}, 32'hB);
      rst = 1'b1;
      tick();
      check("t6_rst_grnt", {28'd0, bus16.m_grnt_}, 32'hF);
      check("t6_rst_vld", {31'd0, bus16.owner_vld}, 32'd0);
      rst = 1'b0;
      bus16.m_req_ = 4'b1010;
      tick();
      check("t6_prio_owner", {30'd0, bus16.owner}, 32'd0);
      check("t6_prio_grnt", {28'd0, bus16.m_grnt_}, 32'hE);
      bus16.m_req_ = 4'b1111;
      tick();

      // Random-request soak on both instances
      for (int c = 0; c < 600; c++) begin
         logic [3:0] r16, r4;
         r16 = bus16.m_req_;
         r4  = bus4.m_req_;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) r16[b] = ~r16[b];
            if ($urandom_range(3) == 0) r4[b]  = ~r4[b];
         end
         bus16.m_req_ = r16;
         bus4.m_req_  = r4;
         prev16 = r16;
         prev4  = r4;
         tick();
         inv("soak16", bus16.m_grnt_, bus16.owner, bus16.owner_vld, prev16);
         inv("soak4", bus4.m_grnt_, bus4.owner, bus4.owner_vld, prev4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
